// File: rtl/cmos_nor_shift_reg.sv
// cmos_nor_shift_reg: WIDTH-bit SIPO shift register built only from two-input NOR cells
// Ports:
//   clk   - clock, shifting on the rising edge
//   rst_n - asynchronous active-low clear of every stage
//   en    - shift enable; when low each stage recirculates its own value
//   d_in  - serial data into stage 0
//   q     - parallel contents, q[0] newest, q[WIDTH-1] oldest
//   d_out - serial output, q[WIDTH-1]

// Two-input NOR cell: the only logic primitive the register is built from.
module cmos_nor (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  nor u_nor (o_y, i_a, i_b);
endmodule

// nor_mux2: o_y = i_sel ? i_b : i_a, built as (a | sel) & (b | ~sel) in NOR form.
module nor_mux2 (
  input  logic i_sel,
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  logic w_sel_n;
  logic w_u;
  logic w_v;
  cmos_nor u_inv_sel (.i_a(i_sel), .i_b(i_sel), .o_y(w_sel_n));
  cmos_nor u_u       (.i_a(i_a),   .i_b(i_sel), .o_y(w_u));
  cmos_nor u_v       (.i_a(i_b),   .i_b(w_sel_n), .o_y(w_v));
  cmos_nor u_y       (.i_a(w_u),   .i_b(w_v),   .o_y(o_y));
endmodule

// nor_dlatch: gated NOR SR latch with dominant clear.
//   i_g   - transparent while high
//   i_clr - active-high clear
//   i_d   - data
//   o_q   - latched value
module nor_dlatch (
  input  logic i_g,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);
  logic w_g_n;
  logic w_d_n;
  logic w_open;
  logic w_open_n;
  logic w_s;
  logic w_t;
  logic w_tc;
  logic w_r;
  logic w_q_n;
  cmos_nor u_inv_g (.i_a(i_g), .i_b(i_g), .o_y(w_g_n));
  cmos_nor u_inv_d (.i_a(i_d), .i_b(i_d), .o_y(w_d_n));
  // S is masked by clear as well as ORing clear into R, so the SR core
  // never sees S=R=1 and cannot race when clear and data release together.
  cmos_nor u_open   (.i_a(w_g_n),  .i_b(i_clr),    .o_y(w_open));
  cmos_nor u_open_n (.i_a(w_open), .i_b(w_open),   .o_y(w_open_n));
  cmos_nor u_s      (.i_a(w_d_n),  .i_b(w_open_n), .o_y(w_s));
  cmos_nor u_t      (.i_a(i_d),    .i_b(w_g_n),    .o_y(w_t));
  cmos_nor u_tc     (.i_a(w_t),    .i_b(i_clr),    .o_y(w_tc));
  cmos_nor u_r      (.i_a(w_tc),   .i_b(w_tc),     .o_y(w_r));
  cmos_nor u_q      (.i_a(w_r),    .i_b(w_q_n),    .o_y(o_q));
  cmos_nor u_q_n    (.i_a(w_s),    .i_b(o_q),      .o_y(w_q_n));
endmodule

// nor_dff: positive-edge master-slave flip-flop with asynchronous clear.
//   i_clk   - clock (slave gate)
//   i_clk_n - inverted clock (master gate)
//   i_clr   - active-high clear into both latches
//   i_d     - data
//   o_q     - stored value
module nor_dff (
  input  logic i_clk,
  input  logic i_clk_n,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);
  logic w_m;
  nor_dlatch u_master (.i_g(i_clk_n), .i_clr(i_clr), .i_d(i_d), .o_q(w_m));
  nor_dlatch u_slave  (.i_g(i_clk),   .i_clr(i_clr), .i_d(w_m), .o_q(o_q));
endmodule

module cmos_nor_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             d_in,
  output logic [WIDTH-1:0] q,
  output logic             d_out
);
  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("cmos_nor_shift_reg: WIDTH %0d outside 2..32", WIDTH);
  end
  logic w_clr;
  logic w_clk_n;
  logic w_last_n;
  cmos_nor u_clr   (.i_a(rst_n), .i_b(rst_n), .o_y(w_clr));
  cmos_nor u_clk_n (.i_a(clk),   .i_b(clk),   .o_y(w_clk_n));
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_nxt;
    // Hold recirculates the stage's own output rather than gating the clock.
    if (i == 0) begin : g_head
      nor_mux2 u_mux (.i_sel(en), .i_a(q[i]), .i_b(d_in), .o_y(w_nxt));
    end else begin : g_tail
      nor_mux2 u_mux (.i_sel(en), .i_a(q[i]), .i_b(q[i-1]), .o_y(w_nxt));
    end
    nor_dff u_dff (
      .i_clk  (clk),
      .i_clk_n(w_clk_n),
      .i_clr  (w_clr),
      .i_d    (w_nxt),
      .o_q    (q[i])
    );
  end
  // Double inversion buffers the last stage onto the serial output.
  cmos_nor u_out_n (.i_a(q[WIDTH-1]), .i_b(q[WIDTH-1]), .o_y(w_last_n));
  cmos_nor u_out   (.i_a(w_last_n),   .i_b(w_last_n),   .o_y(d_out));
endmodule

// File: tb/tb_cmos_nor_shift_reg.sv
// tb_cmos_nor_shift_reg: directed self-checking bench for the NOR-built shift register
module tb_cmos_nor_shift_reg;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       d_in;
  logic [3:0] q4;
  logic [1:0] q2;
  logic [7:0] q8;
  logic       d_out4;
  logic       d_out2;
  logic       d_out8;
  int         checks = 0;
  int         errors = 0;

  cmos_nor_shift_reg #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .en(en), .d_in(d_in), .q(q4), .d_out(d_out4));
  cmos_nor_shift_reg #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .en(en), .d_in(d_in), .q(q2), .d_out(d_out2));
  cmos_nor_shift_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .en(en), .d_in(d_in), .q(q8), .d_out(d_out8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] pat;
    logic [7:0] exp8;
    rst_n = 1'b0;
    en    = 1'b1;
    d_in  = 1'b1;
    #1;
    chk("rst_q4", 32'(q4), 32'h0);
    chk("rst_dout4", 32'(d_out4), 32'h0);
    chk("rst_q2", 32'(q2), 32'h0);
    chk("rst_q8", 32'(q8), 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rst_hold_q4", 32'(q4), 32'h0);
      chk("rst_hold_dout4", 32'(d_out4), 32'h0);
    end
    rst_n = 1'b1;
    step();
    chk("release_first", 32'(q4), 32'h1);

    rst_n = 1'b0;
    #1;
    chk("pulse_clear", 32'(q4), 32'h0);
    rst_n = 1'b1;
    pat = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      d_in = pat[k];
      step();
    end
    chk("fill_1101", 32'(q4), 32'hd);
    d_in = 1'b0;
    pat = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      chk("flush_dout", 32'(d_out4), 32'(pat[k]));
      step();
    end
    chk("flush_empty", 32'(q4), 32'h0);

    pat = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      d_in = pat[k];
      step();
    end
    chk("hold_preload", 32'(q4), 32'ha);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d_in = k[0];
      step();
      chk("hold_q", 32'(q4), 32'ha);
    end
    en = 1'b1;
    d_in = 1'b1;
    step();
    chk("hold_resume", 32'(q4), 32'h5);
    for (int k = 0; k < 4; k++) step();
    chk("all_ones", 32'(q4), 32'hf);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q4", 32'(q4), 32'h0);
    chk("mid_rst_dout4", 32'(d_out4), 32'h0);
    chk("mid_rst_q8", 32'(q8), 32'h0);
    @(negedge clk);
    step();
    chk("mid_rst_edge", 32'(q4), 32'h0);
    rst_n = 1'b1;

    d_in = 1'b0;
    @(posedge clk);
    #1;
    d_in = 1'b1;
    #1;
    chk("setup_high", 32'(q4[0]), 32'h0);
    @(negedge clk);
    chk("setup_low", 32'(q4[0]), 32'h0);
    step();
    chk("setup_next", 32'(q4), 32'h1);

    rst_n = 1'b0;
    #1;
    chk("sweep_clear8", 32'(q8), 32'h0);
    rst_n = 1'b1;
    d_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      d_in = 1'b0;
      exp8 = (e <= 8) ? 8'(1 << (e - 1)) : 8'h0;
      chk("walk_q8", 32'(q8), 32'(exp8));
      chk("walk_dout8", 32'(d_out8), 32'(e == 8));
      chk("walk_dout2", 32'(d_out2), 32'(e == 2));
      chk("walk_dout4", 32'(d_out4), 32'(e == 4));
      chk("walk_known", 32'($isunknown({q2, q4, q8})), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
